// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register writer: frame layout, register map
// and FSM state encodings.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam logic WRITE_BIT = 1'b1;

    // Peripheral register map
    localparam logic [6:0] EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] PWM_DUTY    = 7'h04;
    localparam logic [6:0] MAX_ADDR    = 7'h04;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Assemble the 16-bit write frame sent MSB first
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] a,
                                                          input logic [7:0] d);
        return {WRITE_BIT, a, d};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer and SPI clock level generator. While run is high the
// 8-bit counter cycles 0..CLK_DIV-1 and tick marks the last cycle of each
// half-period; sclk flips on tick only when toggle is high.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic toggle,
    output logic tick,
    output logic sclk
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] half_cnt;

    assign tick = run && (half_cnt == LAST);

    // Half-period counter: held at zero while idle, wraps after CLK_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            half_cnt <= 8'd0;
        else if (!run || tick)
            half_cnt <= 8'd0;
        else
            half_cnt <= half_cnt + 8'd1;
    end

    // SPI clock level: idles low, flips at the end of each half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sclk <= 1'b0;
        else if (!run)
            sclk <= 1'b0;
        else if (tick && toggle)
            sclk <= ~sclk;
    end

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 register writer: sends one 16-bit write frame
// {1, addr[6:0], wdata[7:0]} MSB first per accepted start.
// Optional macro SPI_REG_WRITER_ADDR_CHECK_EN adds an err output and rejects
// addresses above MAX_ADDR without driving a frame.
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
    ,
    output logic       err
`endif
);

    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [3:0]            bit_cnt;
    logic                  active;
    logic                  tick;
    logic                  addr_ok;
    logic                  accept;

`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
    assign addr_ok = (addr <= MAX_ADDR);
`else
    assign addr_ok = 1'b1;
`endif

    assign active = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign accept = (state == ST_IDLE) && start && addr_ok;

    assign ncs  = ~active;
    assign busy = active;
    assign done = (state == ST_DONE);
    assign copi = shift_reg[FRAME_BITS-1];

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (active),
        .toggle(state == ST_SHIFT),
        .tick  (tick),
        .sclk  (sclk)
    );

    // Frame sequencer: capture on accept, shift on each sclk fall, then hold
    // ncs for one half-period before reporting completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SETUP;
                        shift_reg <= build_frame(addr, wdata);
                        bit_cnt   <= 4'd0;
                    end
                end
                ST_SETUP: begin
                    if (tick)
                        state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick && sclk) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                        if (bit_cnt == 4'd15)
                            state <= ST_HOLD;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (tick)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
    // Out-of-range request: one-cycle error pulse, the FSM stays idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else
            err <= (state == ST_IDLE) && start && !addr_ok;
    end
`endif

endmodule
